// File: rtl/best_match_select_pkg.sv
// -----------------------------------------------------------------------------
// best_match_select_pkg
// Shared definitions for the disparity best-match selector and the calc stage:
// FSM state encoding, default data widths and the per-search candidate limit.
// -----------------------------------------------------------------------------
package best_match_select_pkg;

    localparam int unsigned RES_W_DEF    = 18;
    localparam int unsigned PLACE_W_DEF  = 6;
    localparam int unsigned MAX_CAND_DEF = 64;
    localparam int unsigned COUNT_W      = 7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

endpackage : best_match_select_pkg

// File: rtl/best_match_select_score_compare.sv
// -----------------------------------------------------------------------------
// score_compare
// Unsigned strict greater-than between a new correlation score and the
// current best score.
// Ports:
//   i_new   - candidate score
//   i_best  - current best score
//   o_gt_c  - combinational: i_new > i_best
// -----------------------------------------------------------------------------
module score_compare #(
    parameter int unsigned W = 18
) (
    input  logic [W-1:0] i_new,
    input  logic [W-1:0] i_best,
    output logic         o_gt_c
);

    assign o_gt_c = (i_new > i_best);

endmodule : score_compare

// File: rtl/best_match_select.sv
// -----------------------------------------------------------------------------
// best_match_select
// Tracks the highest-scoring candidate over one search window of result/place
// beats and reports it with a one-cycle done pulse.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   lstart        - opens a new search (clears results, aborts any search)
//   rvalid        - result/place beat valid
//   result, place - candidate score and its index
//   finalstart    - current beat is the last of the search
//   best_place    - index of best candidate
//   best_result   - score of best candidate
//   count         - candidates accepted (saturates at MAX_CAND)
//   busy          - searching
//   done          - one-cycle pulse, best_* final
//   overflow      - sticky: candidate arrived beyond MAX_CAND
// -----------------------------------------------------------------------------
module best_match_select
    import best_match_select_pkg::*;
#(
    parameter int unsigned RES_W    = RES_W_DEF,
    parameter int unsigned PLACE_W  = PLACE_W_DEF,
    parameter int unsigned MAX_CAND = MAX_CAND_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               lstart,
    input  logic               rvalid,
    input  logic [RES_W-1:0]   result,
    input  logic [PLACE_W-1:0] place,
    input  logic               finalstart,
    output logic [PLACE_W-1:0] best_place,
    output logic [RES_W-1:0]   best_result,
    output logic [6:0]         count,
    output logic               busy,
    output logic               done,
    output logic               overflow
);

    state_e               r_state;
    state_e               w_next;
    logic [RES_W-1:0]     r_best_result;
    logic [PLACE_W-1:0]   r_best_place;
    logic [COUNT_W-1:0]   r_count;
    logic                 r_overflow;
    logic                 r_busy;
    logic                 r_done;

    logic                 w_accept;
    logic                 w_first;
    logic                 w_room;
    logic                 w_gt;
    logic                 w_take;

    score_compare #(
        .W (RES_W)
    ) u_cmp (
        .i_new  (result),
        .i_best (r_best_result),
        .o_gt_c (w_gt)
    );

    // Candidate qualification and next-state decode.
    // With lstart the stored best is about to be cleared, so a coincident beat
    // is treated as the first of the new search regardless of stale state.
    always_comb begin
        w_next   = r_state;
        w_accept = rvalid && (lstart || (r_state == ST_SEARCH));
        w_first  = lstart || (r_count == '0);
        w_room   = lstart || (r_count < COUNT_W'(MAX_CAND));
        w_take   = w_accept && w_room && (w_first || w_gt);

        unique case (r_state)
            ST_IDLE: begin
                if (lstart) begin
                    w_next = (w_accept && finalstart) ? ST_DONE : ST_SEARCH;
                end
            end
            ST_SEARCH: begin
                if (w_accept && finalstart) begin
                    w_next = ST_DONE;
                end else begin
                    w_next = ST_SEARCH;
                end
            end
            ST_DONE: begin
                if (lstart) begin
                    w_next = (w_accept && finalstart) ? ST_DONE : ST_SEARCH;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // State, flags and best-candidate registers; later assignments override
    // the lstart clear when a candidate arrives in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_best_result <= '0;
            r_best_place  <= '0;
            r_count       <= '0;
            r_overflow    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next == ST_SEARCH);
            r_done  <= (w_next == ST_DONE);

            if (lstart) begin
                r_best_result <= '0;
                r_best_place  <= '0;
                r_count       <= '0;
                r_overflow    <= 1'b0;
            end

            if (w_accept) begin
                if (w_room) begin
                    r_count <= lstart ? COUNT_W'(1) : (r_count + COUNT_W'(1));
                end else begin
                    r_overflow <= 1'b1;
                end
            end

            if (w_take) begin
                r_best_result <= result;
                r_best_place  <= place;
            end
        end
    end

    assign best_place  = r_best_place;
    assign best_result = r_best_result;
    assign count       = r_count;
    assign busy        = r_busy;
    assign done        = r_done;
    assign overflow    = r_overflow;

endmodule : best_match_select

// File: tb/tb_best_match_select.sv
// -----------------------------------------------------------------------------
// tb_best_match_select
// Self-checking bench: table of searches with expected results, queued on the
// scoreboard and popped on each done pulse, plus hand sequences for overflow,
// abort-by-lstart and mid-search reset.
// -----------------------------------------------------------------------------
module tb_best_match_select;

    localparam int unsigned RW = 18;
    localparam int unsigned PW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          lstart;
    logic          rvalid;
    logic [RW-1:0] result;
    logic [PW-1:0] place;
    logic          finalstart;
    logic [PW-1:0] best_place;
    logic [RW-1:0] best_result;
    logic [6:0]    count;
    logic          busy;
    logic          done;
    logic          overflow;

    best_match_select #(
        .RES_W    (RW),
        .PLACE_W  (PW),
        .MAX_CAND (64)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .lstart      (lstart),
        .rvalid      (rvalid),
        .result      (result),
        .place       (place),
        .finalstart  (finalstart),
        .best_place  (best_place),
        .best_result (best_result),
        .count       (count),
        .busy        (busy),
        .done        (done),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PW-1:0] place;
        logic [RW-1:0] res;
        logic [6:0]    cnt;
        logic          ovf;
    } exp_t;

    typedef struct {
        int   n;
        bit   co;
        int   res [8];
        int   plc [8];
        exp_t e;
    } vec_t;

    exp_t sb_q[$];
    vec_t vt[6];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin : mon
        exp_t e;
        if (done === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done: got done=1 expected no pulse at %0t", $time);
            end else begin
                e = sb_q.pop_front();
                chk("sb_best_place",  32'(best_place),  32'(e.place));
                chk("sb_best_result", 32'(best_result), 32'(e.res));
                chk("sb_count",       32'(count),       32'(e.cnt));
                chk("sb_overflow",    32'(overflow),    32'(e.ovf));
                chk("sb_busy_low",    32'(busy),        32'd0);
            end
        end
    end

    task automatic beat(input logic l, input logic v, input logic [RW-1:0] r,
                        input logic [PW-1:0] p, input logic f);
        lstart     = l;
        rvalid     = v;
        result     = r;
        place      = p;
        finalstart = f;
        @(posedge clk);
        #1;
        lstart     = 1'b0;
        rvalid     = 1'b0;
        finalstart = 1'b0;
        result     = '0;
        place      = '0;
    endtask

    task automatic check_outs(input string tag, input exp_t e, input logic b);
        @(negedge clk);
        chk({tag, "_place"},  32'(best_place),  32'(e.place));
        chk({tag, "_result"}, 32'(best_result), 32'(e.res));
        chk({tag, "_count"},  32'(count),       32'(e.cnt));
        chk({tag, "_ovf"},    32'(overflow),    32'(e.ovf));
        chk({tag, "_busy"},   32'(busy),        32'(b));
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        int s;
        sb_q.push_back(v.e);
        if (v.co) begin
            beat(1'b1, 1'b1, RW'(v.res[0]), PW'(v.plc[0]), v.n == 1);
            s = 1;
        end else begin
            beat(1'b1, 1'b0, '0, '0, 1'b0);
            s = 0;
        end
        for (int i = s; i < v.n; i++) begin
            if ($urandom_range(0, 2) == 0) beat(1'b0, 1'b0, '0, '0, 1'b0);
            beat(1'b0, 1'b1, RW'(v.res[i]), PW'(v.plc[i]), i == v.n - 1);
        end
        @(negedge clk);
        chk("done_latency", 32'(done), 32'd1);
        @(posedge clk);
        #1;
        // Beats outside a search must be ignored and results held.
        beat(1'b0, 1'b1, RW'(262143), PW'(33), 1'b1);
        beat(1'b0, 1'b1, RW'(123456), PW'(17), 1'b0);
        check_outs("hold", v.e, 1'b0);
    endtask

    initial begin
        exp_t e0;
        rst = 1'b1; lstart = 1'b0; rvalid = 1'b0; finalstart = 1'b0;
        result = '0; place = '0;

        vt[0].n = 4; vt[0].co = 1'b0;
        vt[0].res = '{5, 9, 9, 3, 0, 0, 0, 0};
        vt[0].plc = '{0, 1, 2, 3, 0, 0, 0, 0};
        vt[0].e   = '{place: 6'd1, res: 18'd9, cnt: 7'd4, ovf: 1'b0};
        vt[1].n = 1; vt[1].co = 1'b1;
        vt[1].res = '{0, 0, 0, 0, 0, 0, 0, 0};
        vt[1].plc = '{7, 0, 0, 0, 0, 0, 0, 0};
        vt[1].e   = '{place: 6'd7, res: 18'd0, cnt: 7'd1, ovf: 1'b0};
        vt[2].n = 3; vt[2].co = 1'b0;
        vt[2].res = '{2, 2, 2, 0, 0, 0, 0, 0};
        vt[2].plc = '{10, 11, 12, 0, 0, 0, 0, 0};
        vt[2].e   = '{place: 6'd10, res: 18'd2, cnt: 7'd3, ovf: 1'b0};
        vt[3].n = 5; vt[3].co = 1'b1;
        vt[3].res = '{100, 50, 40, 30, 20, 0, 0, 0};
        vt[3].plc = '{5, 6, 7, 8, 9, 0, 0, 0};
        vt[3].e   = '{place: 6'd5, res: 18'd100, cnt: 7'd5, ovf: 1'b0};
        vt[4].n = 3; vt[4].co = 1'b0;
        vt[4].res = '{0, 0, 7, 0, 0, 0, 0, 0};
        vt[4].plc = '{1, 2, 3, 0, 0, 0, 0, 0};
        vt[4].e   = '{place: 6'd3, res: 18'd7, cnt: 7'd3, ovf: 1'b0};
        vt[5].n = 2; vt[5].co = 1'b0;
        vt[5].res = '{262143, 262142, 0, 0, 0, 0, 0, 0};
        vt[5].plc = '{63, 0, 0, 0, 0, 0, 0, 0};
        vt[5].e   = '{place: 6'd63, res: 18'h3FFFF, cnt: 7'd2, ovf: 1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        e0 = '{place: '0, res: '0, cnt: '0, ovf: 1'b0};
        @(negedge clk);
        chk("rst_done", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        check_outs("rst", e0, 1'b0);

        for (int i = 0; i < 6; i++) run_vec(vt[i]);

        // 70 increasing candidates: saturate at 64, overflow, best stays at #63
        sb_q.push_back('{place: 6'd63, res: 18'd64, cnt: 7'd64, ovf: 1'b1});
        beat(1'b1, 1'b0, '0, '0, 1'b0);
        for (int i = 0; i < 70; i++) begin
            beat(1'b0, 1'b1, RW'(i + 1), PW'(i), i == 69);
            if (i == 64) begin
                @(negedge clk);
                chk("ovf_mid", 32'(overflow), 32'd1);
                @(posedge clk);
                #1;
            end
        end
        @(negedge clk);
        chk("ovf_done_latency", 32'(done), 32'd1);
        @(posedge clk);
        #1;

        // Abort a search with a fresh lstart: no done, cleared, new data only
        beat(1'b1, 1'b0, '0, '0, 1'b0);
        for (int i = 0; i < 3; i++) beat(1'b0, 1'b1, RW'(1000 + i), PW'(40 + i), 1'b0);
        beat(1'b1, 1'b0, '0, '0, 1'b0);
        check_outs("abort", e0, 1'b1);
        sb_q.push_back('{place: 6'd21, res: 18'd8, cnt: 7'd2, ovf: 1'b0});
        beat(1'b0, 1'b1, RW'(4), PW'(20), 1'b0);
        beat(1'b0, 1'b1, RW'(8), PW'(21), 1'b1);
        @(negedge clk);
        chk("abort_done_latency", 32'(done), 32'd1);
        @(posedge clk);
        #1;

        // Reset mid-search with coincident rvalid+finalstart
        beat(1'b1, 1'b0, '0, '0, 1'b0);
        beat(1'b0, 1'b1, RW'(50), PW'(3), 1'b0);
        beat(1'b0, 1'b1, RW'(60), PW'(4), 1'b0);
        rst = 1'b1;
        rvalid = 1'b1; result = RW'(99); place = PW'(5); finalstart = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; rvalid = 1'b0; finalstart = 1'b0; result = '0; place = '0;
        check_outs("midrst", e0, 1'b0);
        beat(1'b0, 1'b1, RW'(77), PW'(9), 1'b1);
        beat(1'b0, 1'b1, RW'(78), PW'(10), 1'b0);
        check_outs("idle_rv", e0, 1'b0);

        repeat (3) @(posedge clk);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_best_match_select

// File: doc/best_match_select.md
BEST_MATCH_SELECT -- requirements
Module: best_match_select

Interface
REQ-001 The block SHALL have parameter RES_W, default 18, meaning width of the incoming correlation result.
REQ-002 The block SHALL have parameter PLACE_W, default 6, meaning width of the candidate place (disparity) index.
REQ-003 The block SHALL have parameter MAX_CAND, default 64, meaning the maximum number of candidates accepted per search.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port lstart, input, 1 bit: one-cycle pulse that opens a new search.
REQ-007 The block SHALL have port rvalid, input, 1 bit: result/place pair valid this cycle.
REQ-008 The block SHALL have port result, input, RES_W bits: unsigned match score from the calc unit; larger means a better match.
REQ-009 The block SHALL have port place, input, PLACE_W bits: candidate index belonging to result.
REQ-010 The block SHALL have port finalstart, input, 1 bit: marks the current rvalid beat as the last candidate of the search.
REQ-011 The block SHALL have port best_place, output, PLACE_W bits: index of the best candidate.
REQ-012 The block SHALL have port best_result, output, RES_W bits: score of the best candidate.
REQ-013 The block SHALL have port count, output, 7 bits: number of candidates accepted in the current or last search.
REQ-014 The block SHALL have port busy, output, 1 bit: high while in SEARCH.
REQ-015 The block SHALL have port done, output, 1 bit: one-cycle pulse when the best outputs are final.
REQ-016 The block SHALL have port overflow, output, 1 bit: sticky per search; a candidate arrived after MAX_CAND were accepted.

Function
REQ-017 The FSM SHALL have states IDLE, SEARCH and DONE.
REQ-018 IDLE->SEARCH on lstart; SEARCH->DONE on the cycle after an accepted rvalid with finalstart=1; DONE->IDLE unconditionally after one cycle.
REQ-019 On lstart, best_result SHALL clear to 0, best_place to 0, count to 0 and overflow to 0 on the next edge, from any state.
REQ-020 A candidate SHALL be accepted when rvalid=1 and the state is SEARCH, or when rvalid=1 coincides with lstart, in which case it is the first candidate of the new search.
REQ-021 An accepted candidate SHALL replace best_result/best_place only when result is strictly greater than best_result; ties keep the earlier candidate.
REQ-022 The first accepted candidate of a search SHALL always be stored, including result=0.
REQ-023 count SHALL increment by 1 per accepted candidate and saturate at MAX_CAND.
REQ-024 A candidate arriving with count=MAX_CAND SHALL be ignored, set overflow and still honour its finalstart.
REQ-025 rvalid in IDLE or DONE without lstart SHALL be ignored with no output change.
REQ-026 lstart during SEARCH SHALL abort the current search without a done pulse and restart per REQ-019.
REQ-027 Latency: done SHALL assert exactly one cycle after the accepted finalstart beat, with best_* already final in that cycle.
REQ-028 best_place, best_result, count and overflow SHALL hold their values from DONE until the next lstart.
REQ-029 busy SHALL equal (state==SEARCH); done SHALL equal (state==DONE).

Reset
REQ-030 On rst, state SHALL go to IDLE and best_place=0, best_result=0, count=0, busy=0, done=0 and overflow=0 on the next edge.
REQ-031 rst SHALL override lstart and rvalid in the same cycle.
REQ-032 rst mid-search SHALL discard the search with no done pulse.

Structure
REQ-033 A shared package SHALL hold the FSM state encoding and the RES_W/PLACE_W/MAX_CAND defaults, reused by the calc stage.
REQ-034 A single sub-module, score_compare (unsigned strict greater-than), SHALL be used; all other logic lives in this module.

Verification
REQ-035 lstart, then results 5,9,9,3 at places 0,1,2,3 with finalstart on the last -> done one cycle later, best_place=1, best_result=9, count=4.
REQ-036 Single candidate with result=0, place=7, rvalid+lstart+finalstart in the same cycle -> best_place=7, best_result=0, count=1, done next cycle.
REQ-037 70 candidates with increasing scores, finalstart on the 70th -> count=64, overflow=1, best_place=63.
REQ-038 lstart again after 3 candidates in SEARCH -> no done pulse, count=0 then restarts; subsequent search reports only the new data.
REQ-039 rst asserted mid-search with a coincident rvalid -> all outputs 0, state IDLE, no done pulse; rvalid in IDLE afterwards changes nothing.
